// File: rtl/multicycle_controlpath.sv
// Multi-cycle RV32I control path: one FSM sequences fetch/decode/execute/memory/writeback,
// waits on a shared memory with a bounded timeout, and parks in a sticky TRAP state.
module multicycle_controlpath #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Carry,
  input  logic        Referee,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic [3:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause
);
  // Memory handshake: MemRead/MemWrite and AdrSrc stay asserted and stable while mem_ready
  // is low; the transfer completes in the cycle mem_ready is high, and the FSM moves on.
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_JALRADR = 4'd9, S_JAL = 4'd10, S_BRANCH = 4'd11,
    S_UPPER = 4'd12, S_TRAP = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                         ALU_SRA = 4'b1001;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 trap_q;
  logic [1:0]           cause_q, cause_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_instr_bits;
  logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
  logic       br_take, br_bad, timed_out, in_wait;

  assign opcode            = Instr[6:0];
  assign funct3            = Instr[14:12];
  assign funct7b5          = Instr[30];
  assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b5,
                                            input logic is_r);
    case (f3)
      3'b000:  alu_decode = (is_r && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  always_comb begin
    br_take = 1'b0;
    br_bad  = 1'b0;
    case (funct3)
      3'b000:  br_take = Zero;
      3'b001:  br_take = ~Zero;
      3'b100:  br_take = Referee;
      3'b101:  br_take = ~Referee;
      3'b110:  br_take = ~Carry;
      3'b111:  br_take = Carry;
      default: br_bad  = 1'b1;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b011;
      OP_JAL:           ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  // A completing handshake wins over an expiring timeout in the same cycle.
  assign timed_out = (MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_VAL);
  assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALRADR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD, S_MEMWRITE: begin
        mem_read  = (state_q == S_MEMREAD);
        mem_write = (state_q == S_MEMWRITE);
        adr_src   = 1'b1;
        if (mem_ready) begin
          state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (state_q == S_EXECR) ? 2'b00 : 2'b01;
        ALUControl = alu_decode(funct3, funct7b5, state_q == S_EXECR);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_JAL: begin
        pc_write = 1'b1;
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        state_d  = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        pc_write   = br_take;
        if (br_bad) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_UPPER: begin
        ALUSrcA = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // The wait counter only advances while parked in a memory state and saturates at all-ones.
  always_comb begin
    if ((state_d != state_q) || !in_wait) wait_d = '0;
    else if (&wait_q)                     wait_d = wait_q;
    else                                  wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      trap_q  <= trap_q | (state_d == S_TRAP);
      cause_q <= cause_d;
    end
  end

  assign PCWrite    = pc_write & ~rst;
  assign AdrSrc     = adr_src;
  assign MemRead    = mem_read & ~rst;
  assign MemWrite   = mem_write & ~rst;
  assign IRWrite    = ir_write & ~rst;
  assign RegWrite   = reg_write & ~rst;
  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
endmodule

// File: tb/tb_multicycle_controlpath.sv
// Randomized bench for multicycle_controlpath: an instruction-level model expands each
// instruction into its expected per-cycle output trace, which is replayed and compared.
module tb_multicycle_controlpath;
  localparam int TO = 16;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_ALUWB = 4'd8, S_JALRADR = 4'd9, S_JAL = 4'd10, S_BRANCH = 4'd11,
                         S_UPPER = 4'd12, S_TRAP = 4'd15;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_BR = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mrd, mwr, irw, rw;
    logic [1:0] a, b, rs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       trap;
    logic [1:0] cause;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic [2:0]  fl;
    logic [31:0] instr;
    out_t        o;
  } cyc_t;

  localparam int CW = $bits(cyc_t);

  // ALU operations listed by their ALUControl code: funct3 and the funct7b5 they need.
  logic [2:0] op_f3  [10] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100,
                              3'b010, 3'b011, 3'b001, 3'b101, 3'b101};
  logic       op_b30 [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [6:0] legal_ops [9] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR,
                                OP_BR, OP_LUI, OP_AUIPC};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instr;
  logic        Zero, Carry, Referee, mem_ready;
  logic        PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl, state;
  logic        trap;
  logic [1:0]  trap_cause;
  out_t        obs;

  logic [CW-1:0] exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            ncyc = 0;
  logic [31:0]   m_instr;
  logic [2:0]    m_imm;
  logic          m_trap;
  logic [1:0]    m_cause;

  multicycle_controlpath #(.MEM_TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero), .Carry(Carry), .Referee(Referee),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .state(state), .trap(trap), .trap_cause(trap_cause)
  );

  assign obs = {state, PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, trap, trap_cause};

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] rf();
    return 3'($urandom);
  endfunction

  function automatic logic rmr();
    return 1'($urandom);
  endfunction

  function automatic out_t base(input logic [3:0] st);
    out_t o;
    o       = '0;
    o.st    = st;
    o.imm   = m_imm;
    o.trap  = m_trap;
    o.cause = m_cause;
    return o;
  endfunction

  function automatic logic [3:0] alu_expect(input bit is_r, input logic [2:0] f3,
                                            input logic b30);
    for (int k = 0; k < 10; k++) begin
      bit b30_matters;
      b30_matters = (k == 8) || (k == 9) || (is_r && (k == 0 || k == 1));
      if (!is_r && k == 1) continue;
      if (op_f3[k] == f3 && (!b30_matters || op_b30[k] == b30)) return 4'(k);
    end
    return 4'hF;
  endfunction

  function automatic logic br_expect(input logic [2:0] f3, input logic [2:0] fl);
    logic z, c, r;
    {z, c, r} = fl;
    case (f3)
      3'b000:  return z;       // beq
      3'b001:  return !z;      // bne
      3'b100:  return r;       // blt
      3'b101:  return !r;      // bge
      3'b110:  return !c;      // bltu: borrow out means rs1 < rs2
      3'b111:  return c;       // bgeu
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input out_t o, input logic mr, input logic [2:0] fl);
    cyc_t c;
    c.rst   = 1'b0;
    c.mr    = mr;
    c.fl    = fl;
    c.instr = m_instr;
    c.o     = o;
    exp_q.push_back(c);
  endtask

  // Converts the newest queued cycle into a reset cycle: enables dropped, model state cleared.
  task automatic make_last_reset();
    cyc_t c;
    c = exp_q[exp_q.size()-1];
    c.rst = 1'b1;
    {c.o.pcw, c.o.mrd, c.o.mwr, c.o.irw, c.o.rw} = '0;
    exp_q[exp_q.size()-1] = c;
    m_trap  = 1'b0;
    m_cause = 2'b00;
  endtask

  task automatic trap_tail(input logic [1:0] cause, input int n);
    m_trap  = 1'b1;
    m_cause = cause;
    for (int i = 0; i < n; i++) push(base(S_TRAP), rmr(), rf());
    push(base(S_TRAP), rmr(), rf());
    make_last_reset();
  endtask

  // w < 0 means the memory never answers and the wait runs into the timeout.
  task automatic wait_phase(input out_t o, input int w, output bit to);
    to = (w < 0);
    for (int i = 0; i < (to ? TO + 1 : w); i++) push(o, 1'b0, rf());
  endtask

  task automatic alu_wb();
    out_t o;
    o = base(S_ALUWB);
    o.rw = 1'b1;
    push(o, rmr(), rf());
  endtask

  task automatic jal_step();
    out_t o;
    o = base(S_JAL);
    o.pcw = 1'b1;
    o.a   = 2'b01;
    o.b   = 2'b10;
    push(o, rmr(), rf());
  endtask

  task automatic build(input logic [31:0] ins, input int fw, input int mw, input int ntrap,
                       input int bfl);
    out_t o;
    bit to;
    logic [6:0] opc;
    logic [2:0] fl;
    opc     = ins[6:0];
    m_instr = ins;
    case (opc)
      OP_STORE:         m_imm = 3'b001;
      OP_BR:            m_imm = 3'b010;
      OP_LUI, OP_AUIPC: m_imm = 3'b011;
      OP_JAL:           m_imm = 3'b100;
      default:          m_imm = 3'b000;
    endcase
    o = base(S_FETCH);
    o.mrd = 1'b1;
    o.b   = 2'b10;
    o.rs  = 2'b10;
    wait_phase(o, fw, to);
    if (to) begin
      trap_tail(2'b10, ntrap);
      return;
    end
    o.pcw = 1'b1;
    o.irw = 1'b1;
    push(o, 1'b1, rf());
    o = base(S_DECODE);
    o.a = 2'b01;
    o.b = 2'b01;
    push(o, rmr(), rf());
    case (opc)
      OP_LOAD, OP_STORE: begin
        o = base(S_MEMADR);
        o.a = 2'b10;
        o.b = 2'b01;
        push(o, rmr(), rf());
        o = base(opc == OP_LOAD ? S_MEMREAD : S_MEMWRITE);
        o.adr = 1'b1;
        o.mrd = (opc == OP_LOAD);
        o.mwr = (opc == OP_STORE);
        wait_phase(o, mw, to);
        if (to) begin
          trap_tail(2'b10, ntrap);
          return;
        end
        push(o, 1'b1, rf());
        if (opc == OP_LOAD) begin
          o = base(S_MEMWB);
          o.rs = 2'b01;
          o.rw = 1'b1;
          push(o, rmr(), rf());
        end
      end
      OP_R, OP_I: begin
        o = base(opc == OP_R ? S_EXECR : S_EXECI);
        o.a   = 2'b10;
        o.b   = (opc == OP_R) ? 2'b00 : 2'b01;
        o.alu = alu_expect(opc == OP_R, ins[14:12], ins[30]);
        push(o, rmr(), rf());
        alu_wb();
      end
      OP_JAL: begin
        jal_step();
        alu_wb();
      end
      OP_JALR: begin
        o = base(S_JALRADR);
        o.a = 2'b10;
        o.b = 2'b01;
        push(o, rmr(), rf());
        jal_step();
        alu_wb();
      end
      OP_BR: begin
        fl = (bfl < 0) ? rf() : 3'(bfl);
        o = base(S_BRANCH);
        o.a   = 2'b10;
        o.alu = 4'b0001;
        o.pcw = br_expect(ins[14:12], fl);
        push(o, rmr(), fl);
        if (ins[14:13] == 2'b01) trap_tail(2'b01, ntrap);
      end
      OP_LUI, OP_AUIPC: begin
        o = base(S_UPPER);
        o.a = (opc == OP_LUI) ? 2'b11 : 2'b01;
        o.b = 2'b01;
        push(o, rmr(), rf());
        alu_wb();
      end
      default: trap_tail(2'b01, ntrap);
    endcase
  endtask

  // driver: replays the expected trace, driving inputs at negedge and checking 1ns later
  task automatic drain();
    cyc_t c;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      @(negedge clk);
      rst       = c.rst;
      mem_ready = c.mr;
      {Zero, Carry, Referee} = c.fl;
      Instr     = c.instr;
      #1;
      check_eq($sformatf("cyc%0d_st%0d", ncyc, c.o.st), 32'(obs), 32'(c.o));
      ncyc++;
    end
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return -1;
    if (r == 1) return TO;
    return $urandom_range(0, 3);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0] opc;
    int cls;
    ins = $urandom;
    cls = $urandom_range(0, 9);
    if (cls < 9) begin
      opc = legal_ops[cls];
    end else begin
      do opc = 7'($urandom); while (opc inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL,
                                                OP_JALR, OP_BR, OP_LUI, OP_AUIPC});
    end
    ins[6:0] = opc;
    return ins;
  endfunction

  initial begin
    int k;
    rst       = 1'b1;
    mem_ready = 1'b0;
    Instr     = 32'h0000_0013;
    {Zero, Carry, Referee} = 3'b000;
    m_trap    = 1'b0;
    m_cause   = 2'b00;
    m_instr   = 32'h0000_0013;
    m_imm     = 3'b000;
    repeat (2) @(negedge clk);

    // reset state, with mem_ready high so a missing enable gate would show up
    begin
      out_t o;
      o = base(S_FETCH);
      o.b  = 2'b10;
      o.rs = 2'b10;
      push(o, 1'b1, 3'b000);
      make_last_reset();
    end
    drain();

    build(32'h0020_81B3, 0, 0, 1, -1);        // add x3,x1,x2
    build(32'h0000_A183, 0, 3, 1, -1);        // lw with 3 wait cycles
    build(32'h0020_E063, 0, 0, 1, 3'b000);    // bltu, Carry=0 -> taken
    build(32'h0020_F063, 0, 0, 1, 3'b000);    // bgeu, Carry=0 -> not taken
    build(32'h0000_80E7, 0, 0, 1, -1);        // jalr
    build(32'h0000_007F, 0, 0, 20, -1);       // illegal opcode, held 20 cycles
    build(32'h0020_81B3, -1, 0, 3, -1);       // fetch timeout
    build(32'h0020_81B3, TO, 0, 1, -1);       // ready on the reaching cycle
    build(32'h0020_A023, 1, -1, 2, -1);       // sw that times out in MEMWRITE
    build(32'h0020_A023, 2, TO, 2, -1);       // sw completing on the reaching cycle
    build(32'h0020_2063, 0, 0, 2, -1);        // branch funct3 010 traps
    drain();

    for (int n = 0; n < 250; n++) begin
      build(rand_instr(), rand_wait(), rand_wait(), $urandom_range(0, 4), -1);
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(0, exp_q.size() - 1);
        while (exp_q.size() > k + 1) void'(exp_q.pop_back());
        make_last_reset();
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
